// File: rtl/risc_reg_dump.sv
// Post-halt register-file dump engine: waits for a halt instruction,
// lets the core settle, then streams every register out over valid/ready.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   instr                core instruction word, watched for HALT_OPCODE
//   dbg_pc_low           core PC, captured into halt_pc on halt
//   rf_raddr / rf_rdata  register-file read port (rdata sampled at the
//                        end of the READ cycle)
//   dump_valid/ready     output word handshake
//   dump_idx/dump_data   register index and value of the dump word
//   halt_pc              PC captured at halt detection
//   busy                 dump in progress
//   done                 dump finished; sticky until reset
module risc_reg_dump #(
  parameter int              DATA_W      = 32,
  parameter int              ADDR_W      = 12,
  parameter int              NUM_REGS    = 256,
  parameter int              RA_W        = 8,
  parameter int              SETTLE_CYC  = 10,
  parameter logic [DATA_W-1:0] HALT_OPCODE = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] instr,
  input  logic [ADDR_W-1:0] dbg_pc_low,
  output logic [RA_W-1:0]   rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [RA_W-1:0]   dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] halt_pc,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W =
    (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(SETTLE_CYC - 1);

  localparam logic [RA_W-1:0] LAST_IDX =
    RA_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [RA_W-1:0]     r_idx;
  logic [RA_W-1:0]     w_idx_nxt;
  logic                r_valid;
  logic                w_valid_nxt;
  logic [RA_W-1:0]     r_didx;
  logic [RA_W-1:0]     w_didx_nxt;
  logic [DATA_W-1:0]   r_ddata;
  logic [DATA_W-1:0]   w_ddata_nxt;
  logic [ADDR_W-1:0]   r_hpc;
  logic [ADDR_W-1:0]   w_hpc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_didx  <= '0;
      r_ddata <= '0;
      r_hpc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_didx  <= w_didx_nxt;
      r_ddata <= w_ddata_nxt;
      r_hpc   <= w_hpc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_didx_nxt  = r_didx;
    w_ddata_nxt = r_ddata;
    w_hpc_nxt   = r_hpc;
    unique case (r_state)
      S_IDLE: begin
        if (instr == HALT_OPCODE) begin
          w_hpc_nxt   = dbg_pc_low;
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_READ;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_READ: begin
        // rf_raddr has shown r_idx for this whole cycle
        w_ddata_nxt = rf_rdata;
        w_didx_nxt  = r_idx;
        w_valid_nxt = 1'b1;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (dump_ready) begin
          w_valid_nxt = 1'b0;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_idx + RA_W'(1);
            w_state_nxt = S_READ;
          end
        end
      end
      S_DONE: begin
        // sticky until reset; halt ignored
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign rf_raddr   = r_idx;
  assign dump_valid = r_valid;
  assign dump_idx   = r_didx;
  assign dump_data  = r_ddata;
  assign halt_pc    = r_hpc;
  assign busy       = (r_state == S_SETTLE) ||
                      (r_state == S_READ)   ||
                      (r_state == S_SEND);
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_risc_reg_dump.sv
// Directed bench for risc_reg_dump: full dump, backpressure, halt pulse,
// mid-dump reset, post-done halt, and a small 16-register configuration.
module tb_risc_reg_dump;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic [31:0] instr;
  logic [11:0] pc;
  logic [7:0]  raddr;
  logic [31:0] rdata;
  logic        valid;
  logic        ready;
  logic [7:0]  didx;
  logic [31:0] ddata;
  logic [11:0] hpc;
  logic        busy;
  logic        done;

  logic [31:0] instr2;
  logic [11:0] pc2;
  logic [7:0]  raddr2;
  logic [31:0] rdata2;
  logic        valid2;
  logic        ready2;
  logic [7:0]  didx2;
  logic [31:0] ddata2;
  logic [11:0] hpc2;
  logic        busy2;
  logic        done2;

  assign rdata  = {24'd0, raddr} * 32'd3;
  assign rdata2 = {24'd0, raddr2} * 32'd5 + 32'd1;

  risc_reg_dump u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .dbg_pc_low (pc),
    .rf_raddr   (raddr),
    .rf_rdata   (rdata),
    .dump_valid (valid),
    .dump_ready (ready),
    .dump_idx   (didx),
    .dump_data  (ddata),
    .halt_pc    (hpc),
    .busy       (busy),
    .done       (done)
  );

  risc_reg_dump #(
    .NUM_REGS   (16),
    .SETTLE_CYC (1)
  ) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr2),
    .dbg_pc_low (pc2),
    .rf_raddr   (raddr2),
    .rf_rdata   (rdata2),
    .dump_valid (valid2),
    .dump_ready (ready2),
    .dump_idx   (didx2),
    .dump_data  (ddata2),
    .halt_pc    (hpc2),
    .busy       (busy2),
    .done       (done2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    int n;
    int k;
    int cyc;
    int nv;

    rst_n  = 1'b0;
    instr  = '0;
    pc     = '0;
    ready  = 1'b1;
    instr2 = '0;
    pc2    = '0;
    ready2 = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hpc", hpc, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_idx", didx, 0);
    chk("rst_data", ddata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // one-cycle halt pulse, then NOPs and a moving PC
    instr = HALT;
    pc    = 12'h03C;
    @(posedge clk); #1;
    chk("halt_busy", busy, 1);
    chk("halt_pc", hpc, 12'h03C);
    chk("settle_raddr", raddr, 0);
    @(negedge clk);
    instr = NOP;
    pc    = 12'h777;
    n = 0;
    while (!valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("first_latency", n, 11);

    k = 0;
    cyc = 0;
    while (k < 256 && cyc < 3000) begin
      if (valid) begin
        chk("word_idx", didx, k);
        chk("word_data", ddata, k * 3);
        if (k == 7) begin
          ready = 1'b0;
          for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", valid, 1);
            chk("bp_idx", didx, 7);
            chk("bp_data", ddata, 21);
          end
          ready = 1'b1;
        end
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("word_count", k, 256);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_valid", valid, 0);
    chk("end_idx", didx, 255);
    chk("end_data", ddata, 765);
    chk("end_hpc", hpc, 12'h03C);

    // halt again after done: ignored
    @(negedge clk);
    instr = HALT;
    pc    = 12'h111;
    nv = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (valid) nv++;
    end
    chk("redump_valid", nv, 0);
    chk("redump_done", done, 1);
    chk("redump_hpc", hpc, 12'h03C);
    @(negedge clk);
    instr = NOP;

    // reset in the middle of the dump
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    instr = HALT;
    pc    = 12'h055;
    @(posedge clk); #1;
    @(negedge clk);
    instr = NOP;
    cyc = 0;
    while (!(valid && didx == 8'd100) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("mid_idx", didx, 100);
    chk("mid_data", ddata, 300);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_idx", didx, 0);
    chk("arst_data", ddata, 0);
    chk("arst_hpc", hpc, 0);
    chk("arst_raddr", raddr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    instr = HALT;
    pc    = 12'h0AA;
    @(posedge clk); #1;
    @(negedge clk);
    instr = NOP;
    n = 0;
    while (!valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("restart_latency", n, 11);
    chk("restart_idx", didx, 0);
    chk("restart_data", ddata, 0);
    chk("restart_hpc", hpc, 12'h0AA);

    // 16 registers, one settle cycle
    @(negedge clk);
    instr2 = HALT;
    pc2    = 12'h123;
    @(posedge clk); #1;
    @(negedge clk);
    instr2 = NOP;
    n = 0;
    while (!valid2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("s_latency", n, 2);
    k = 0;
    cyc = 0;
    while (k < 16 && cyc < 200) begin
      if (valid2) begin
        chk("s_idx", didx2, k);
        chk("s_data", ddata2, k * 5 + 1);
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("s_count", k, 16);
    chk("s_done", done2, 1);
    chk("s_busy", busy2, 0);
    chk("s_valid", valid2, 0);
    chk("s_raddr", raddr2, 15);
    chk("s_hpc", hpc2, 12'h123);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
